resamp_gain_path: RTL and testbench

Multi-channel decimate/scale/interpolate path: per-channel boxcar decimation by SAMPLE_RATE, registered gain stage, an internal elastic FIFO holding all channels as one word, and a DAC-paced interpolator with zero-order-hold or linear mode. It is the parametrised successor to the downsample → FIFO → half-amplitude → FIFO → interpolation chain. It sits between the DDS/ADC sample source and the DAC driver, in a single clock domain. It adds run-time gain, interpolation mode, priming and overflow/underrun reporting.

---
 rtl/resamp_gain_path.sv | 191 +++++++++++++++++++
 tb/tb_resamp_gain_path.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/resamp_gain_path.sv
// Multi-channel boxcar decimator, registered gain, elastic FIFO and DAC-paced
// interpolator (zero-order hold or linear) in one clock domain.
module resamp_gain_path #(
    parameter int DATA_WIDTH  = 14,
    parameter int CHANNELS    = 2,
    parameter int SAMPLE_RATE = 4,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             in_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0]   data_in,
    input  logic [1:0]                       gain_sel,
    input  logic                             interp_mode,
    input  logic                             dac_tick,
    input  logic                             clr_flags,
    output logic [CHANNELS*DATA_WIDTH-1:0]   data_out,
    output logic                             out_valid,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
    output logic                             running,
    output logic                             overflow,
    output logic                             underrun
);
    localparam int L     = $clog2(SAMPLE_RATE);
    localparam int ACC_W = DATA_WIDTH + L;
    localparam int WW    = CHANNELS * DATA_WIDTH;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int PW    = DATA_WIDTH + L + 2;

    typedef enum logic {PRIME = 1'b0, RUN = 1'b1} state_t;

    logic [L-1:0]            phase_q;
    logic signed [ACC_W-1:0] acc_q [CHANNELS];
    logic                    dec_vld_q;
    logic [WW-1:0]           gain_d, gain_q;
    logic                    wr_q;
    logic [WW-1:0]           mem_q [FIFO_DEPTH];
    logic [AW-1:0]           wptr_q, rptr_q;
    logic [CW-1:0]           count_q;
    logic                    pop_req, pop_ok, push_ok;
    state_t                  state_q, state_d;
    logic [L-1:0]            k_q, k_d;
    logic [WW-1:0]           prev_q, prev_d, cur_q, cur_d, dout_q, dout_d;
    logic                    ovalid_q, ovalid_d, urun_set;
    logic                    ovf_q, urun_q;

    // Decimator: the first sample of each block loads, the rest accumulate.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            phase_q   <= '0;
            dec_vld_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
        end else begin
            dec_vld_q <= in_valid && (phase_q == L'(SAMPLE_RATE - 1));
            if (in_valid) begin
                phase_q <= phase_q + L'(1);
                for (int c = 0; c < CHANNELS; c++) begin
                    if (phase_q == '0)
                        acc_q[c] <= ACC_W'($signed(data_in[c*DATA_WIDTH +: DATA_WIDTH]));
                    else
                        acc_q[c] <= acc_q[c] + ACC_W'($signed(data_in[c*DATA_WIDTH +: DATA_WIDTH]));
                end
            end
        end
    end

    always_comb begin
        gain_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (gain_sel != 2'b11)
                gain_d[c*DATA_WIDTH +: DATA_WIDTH] = $signed(acc_q[c][ACC_W-1:L]) >>> gain_sel;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            gain_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            wr_q <= dec_vld_q;
            if (dec_vld_q) gain_q <= gain_d;
        end
    end

    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    assign pop_ok  = pop_req && (count_q != '0);
    assign push_ok = wr_q && ((count_q != CW'(FIFO_DEPTH)) || pop_ok);

    always_ff @(posedge clk_in) begin
        if (push_ok) mem_q[wptr_q] <= gain_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop_ok)  rptr_q <= rptr_q + AW'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
            else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= PRIME;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PRIME: if (count_q >= CW'(FIFO_DEPTH / 2)) state_d = RUN;
            RUN:   if (dac_tick && (k_q == '0) && (count_q == '0)) state_d = PRIME;
            default: state_d = PRIME;
        endcase
    end

    always_comb begin
        running = (state_q == RUN);
        pop_req = (state_q == RUN) && dac_tick && (k_q == '0);
    end

    always_comb begin
        logic signed [DATA_WIDTH:0] diff;
        logic signed [PW-1:0]       prod, kx, lin;
        prev_d   = prev_q;
        cur_d    = cur_q;
        k_d      = k_q;
        dout_d   = dout_q;
        ovalid_d = 1'b0;
        urun_set = 1'b0;
        diff     = '0;
        prod     = '0;
        lin      = '0;
        kx       = PW'(k_q);
        if (running && dac_tick) begin
            if ((k_q == '0) && !pop_ok) begin
                urun_set = 1'b1;
            end else begin
                if (k_q == '0) begin
                    prev_d = cur_q;
                    cur_d  = mem_q[rptr_q];
                end
                for (int c = 0; c < CHANNELS; c++) begin
                    diff = (DATA_WIDTH+1)'($signed(cur_d[c*DATA_WIDTH +: DATA_WIDTH]))
                         - (DATA_WIDTH+1)'($signed(prev_d[c*DATA_WIDTH +: DATA_WIDTH]));
                    prod = PW'(diff) * kx;
                    lin  = prod >>> L;
                    if (interp_mode)
                        dout_d[c*DATA_WIDTH +: DATA_WIDTH] = prev_d[c*DATA_WIDTH +: DATA_WIDTH]
                                                           + lin[DATA_WIDTH-1:0];
                    else
                        dout_d[c*DATA_WIDTH +: DATA_WIDTH] = cur_d[c*DATA_WIDTH +: DATA_WIDTH];
                end
                k_d      = k_q + L'(1);
                ovalid_d = 1'b1;
            end
        end
    end

    // Flags: a new event in the same cycle as clr_flags keeps the flag set.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            k_q      <= '0;
            prev_q   <= '0;
            cur_q    <= '0;
            dout_q   <= '0;
            ovalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            urun_q   <= 1'b0;
        end else begin
            k_q      <= k_d;
            prev_q   <= prev_d;
            cur_q    <= cur_d;
            dout_q   <= dout_d;
            ovalid_q <= ovalid_d;
            ovf_q    <= (wr_q && !push_ok) || (ovf_q && !clr_flags);
            urun_q   <= urun_set || (urun_q && !clr_flags);
        end
    end

    assign data_out   = dout_q;
    assign out_valid  = ovalid_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign underrun   = urun_q;

endmodule

// File: tb/tb_resamp_gain_path.sv
// Directed bench for resamp_gain_path: R=4, two channels, 8-word FIFO.
module tb_resamp_gain_path;
    localparam int DW  = 14;
    localparam int CH  = 2;
    localparam int R   = 4;
    localparam int DEP = 8;
    localparam int WW  = DW * CH;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               in_valid, interp_mode, dac_tick, clr_flags;
    logic [WW-1:0]      data_in, data_out;
    logic [1:0]         gain_sel;
    logic               out_valid, running, overflow, underrun;
    logic [$clog2(DEP):0] fifo_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [WW-1:0] obs [$];

    resamp_gain_path #(.DATA_WIDTH(DW), .CHANNELS(CH), .SAMPLE_RATE(R), .FIFO_DEPTH(DEP)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .data_in(data_in),
        .gain_sel(gain_sel), .interp_mode(interp_mode), .dac_tick(dac_tick),
        .clr_flags(clr_flags), .data_out(data_out), .out_valid(out_valid),
        .fifo_count(fifo_count), .running(running), .overflow(overflow), .underrun(underrun)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) if (out_valid) obs.push_back(data_out);

    function automatic logic [WW-1:0] pk(int a, int b);
        return {b[DW-1:0], a[DW-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic feed_word(input int a, input int b);
        repeat (R) begin
            in_valid = 1'b1;
            data_in  = pk(a, b);
            @(negedge clk_in);
            in_valid = 1'b0;
            @(negedge clk_in);
        end
    endtask

    task automatic ticks(input int n, input int gap);
        repeat (n) begin
            dac_tick = 1'b1;
            @(negedge clk_in);
            dac_tick = 1'b0;
            idle(gap);
        end
        idle(2);
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        idle(2);
        rst_in = 1'b1;
        idle(1);
    endtask

    task automatic chk_outs(input string tag, input int base, input logic [WW-1:0] exp [$]);
        chk({tag, "_n"}, 64'(obs.size() - base), 64'(exp.size()));
        foreach (exp[i])
            if (base + i < obs.size()) chk($sformatf("%s_%0d", tag, i), 64'(obs[base+i]), 64'(exp[i]));
    endtask

    initial begin
        logic [WW-1:0] exp [$];
        int base;
        rst_in = 1'b1; in_valid = 1'b0; data_in = '0; gain_sel = 2'b00;
        interp_mode = 1'b0; dac_tick = 1'b0; clr_flags = 1'b0;
        idle(1);
        do_reset();
        chk("rst_dout", 64'(data_out), 0);
        chk("rst_ovalid", 64'(out_valid), 0);
        chk("rst_count", 64'(fifo_count), 0);
        chk("rst_run", 64'(running), 0);
        chk("rst_flags", 64'({overflow, underrun}), 0);

        // unity gain, zero-order hold
        repeat (6) feed_word(1000, -1000);
        idle(5);
        chk("zoh_count", 64'(fifo_count), 6);
        chk("zoh_run", 64'(running), 1);
        base = obs.size();
        ticks(8, 1);
        exp = {};
        repeat (8) exp.push_back(pk(1000, -1000));
        chk_outs("zoh", base, exp);
        chk("zoh_count2", 64'(fifo_count), 4);
        chk("zoh_flags", 64'({overflow, underrun}), 0);

        // gain steps and floor rounding, back-to-back ticks
        do_reset();
        gain_sel = 2'b01; feed_word(-3, 5); idle(1);
        gain_sel = 2'b00; feed_word(-3, 5); idle(1);
        gain_sel = 2'b11; feed_word(-3, 5); idle(1);
        gain_sel = 2'b10; feed_word(8191, -8192);
        idle(5);
        gain_sel = 2'b00;
        chk("gain_run", 64'(running), 1);
        base = obs.size();
        ticks(16, 0);
        exp = {};
        repeat (4) exp.push_back(pk(-2, 2));
        repeat (4) exp.push_back(pk(-3, 5));
        repeat (4) exp.push_back(pk(0, 0));
        repeat (4) exp.push_back(pk(2047, -2048));
        chk_outs("gain", base, exp);

        // linear interpolation
        do_reset();
        interp_mode = 1'b1;
        feed_word(0, 0);
        repeat (3) feed_word(400, -400);
        idle(5);
        base = obs.size();
        ticks(12, 1);
        exp = {};
        repeat (4) exp.push_back(pk(0, 0));
        exp.push_back(pk(0, 0));     exp.push_back(pk(100, -100));
        exp.push_back(pk(200, -200)); exp.push_back(pk(300, -300));
        repeat (4) exp.push_back(pk(400, -400));
        chk_outs("lin", base, exp);
        interp_mode = 1'b0;

        // overflow, then drain across the pointer wrap
        do_reset();
        for (int i = 1; i <= DEP + 3; i++) feed_word(10 * i, -i);
        idle(5);
        chk("ovf_count", 64'(fifo_count), DEP);
        chk("ovf_flag", 64'(overflow), 1);
        chk("ovf_run", 64'(running), 1);
        base = obs.size();
        ticks(DEP * R, 1);
        exp = {};
        for (int i = 1; i <= DEP; i++) repeat (R) exp.push_back(pk(10 * i, -i));
        chk_outs("drain", base, exp);
        chk("drain_count", 64'(fifo_count), 0);

        // underrun: FIFO empty at a block boundary
        base = obs.size();
        ticks(1, 1);
        chk("ur_flag", 64'(underrun), 1);
        chk("ur_run", 64'(running), 0);
        chk("ur_hold", 64'(data_out), 64'(pk(10 * DEP, -DEP)));
        chk("ur_noout", 64'(obs.size() - base), 0);
        repeat (DEP / 2) feed_word(7, 7);
        idle(5);
        chk("ur_rerun", 64'(running), 1);
        chk("ur_sticky", 64'(underrun), 1);
        clr_flags = 1'b1; idle(1); clr_flags = 1'b0; idle(1);
        chk("clr_flags", 64'({overflow, underrun}), 0);
        base = obs.size();
        ticks(2, 1);
        exp = {};
        repeat (2) exp.push_back(pk(7, 7));
        chk_outs("resume", base, exp);

        // asynchronous reset between clock edges
        #2 rst_in = 1'b0;
        #1;
        chk("arst_dout", 64'(data_out), 0);
        chk("arst_misc", 64'({out_valid, running, overflow, underrun}), 0);
        chk("arst_count", 64'(fifo_count), 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        idle(1);
        repeat (DEP / 2 - 1) feed_word(55, -55);
        idle(5);
        chk("reprime_run", 64'(running), 0);
        chk("reprime_count", 64'(fifo_count), DEP / 2 - 1);
        base = obs.size();
        ticks(1, 1);
        chk("prime_tick_ign", 64'(obs.size() - base), 0);
        feed_word(55, -55);
        idle(5);
        chk("reprime_run2", 64'(running), 1);
        ticks(1, 1);
        exp = {};
        exp.push_back(pk(55, -55));
        chk_outs("reprime", base, exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
